// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between two requesters and the shared-ALU arbiter.
`default_nettype none

interface alu_share_arbiter_if #(
  parameter int XLEN = 32
);
  logic            req0_valid;
  logic            req0_ready;
  logic [XLEN-1:0] req0_op1;
  logic [XLEN-1:0] req0_op2;
  logic [2:0]      req0_fn;
  logic [6:0]      req0_fn_ext;

  logic            req1_valid;
  logic            req1_ready;
  logic [XLEN-1:0] req1_op1;
  logic [XLEN-1:0] req1_op2;
  logic [2:0]      req1_fn;
  logic [6:0]      req1_fn_ext;

  logic            rsp0_valid;
  logic            rsp0_ready;
  logic            rsp1_valid;
  logic            rsp1_ready;
  logic [XLEN-1:0] rsp_data;

  modport master (
    output req0_valid, req0_op1, req0_op2, req0_fn, req0_fn_ext,
    output req1_valid, req1_op1, req1_op2, req1_fn, req1_fn_ext,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_data,
    output rsp0_ready, rsp1_ready
  );

  modport slave (
    input  req0_valid, req0_op1, req0_op2, req0_fn, req0_fn_ext,
    input  req1_valid, req1_op1, req1_op2, req1_fn, req1_fn_ext,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_data,
    input  rsp0_ready, rsp1_ready
  );
endinterface

`default_nettype wire

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational RISC-V ALU between
// two requesters: accept -> EXEC (ALU evaluates) -> RESP (hold until consumed).
`default_nettype none

module alu_share_arbiter #(
  parameter int XLEN      = 32,
  parameter bit INIT_PRIO = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  alu_share_arbiter_if.slave  bus,
  output logic [XLEN-1:0]     alu_op1,
  output logic [XLEN-1:0]     alu_op2,
  output logic [2:0]          alu_fn,
  output logic [6:0]          alu_fn_ext,
  input  logic [XLEN-1:0]     alu_res,
  output logic                busy,
  output logic                owner
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            prio_q;
  logic            owner_q;
  logic [XLEN-1:0] op1_q, op2_q, rsp_q;
  logic [2:0]      fn_q;
  logic [6:0]      fn_ext_q;

  logic            grant_vld;
  logic            grant_id;
  logic            rsp_rdy_sel;

  assign rsp_rdy_sel = owner_q ? bus.rsp1_ready : bus.rsp0_ready;

  // Grants are only issued in IDLE, so ready already implies state==IDLE.
  always_comb begin
    state_d   = state_q;
    grant_vld = 1'b0;
    grant_id  = prio_q;
    if (state_q == S_IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = prio_q;
      end else if (bus.req0_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b0;
      end else if (bus.req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b1;
      end
    end
    case (state_q)
      S_IDLE:  if (grant_vld) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rsp_rdy_sel) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      prio_q   <= INIT_PRIO;
      owner_q  <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      fn_q     <= '0;
      fn_ext_q <= '0;
      rsp_q    <= '0;
    end else begin
      state_q <= state_d;
      if (grant_vld) begin
        op1_q    <= grant_id ? bus.req1_op1    : bus.req0_op1;
        op2_q    <= grant_id ? bus.req1_op2    : bus.req0_op2;
        fn_q     <= grant_id ? bus.req1_fn     : bus.req0_fn;
        fn_ext_q <= grant_id ? bus.req1_fn_ext : bus.req0_fn_ext;
        owner_q  <= grant_id;
        prio_q   <= ~grant_id;
      end
      if (state_q == S_EXEC) begin
        rsp_q <= alu_res;
      end
    end
  end

  assign bus.req0_ready = grant_vld && !grant_id;
  assign bus.req1_ready = grant_vld &&  grant_id;
  assign bus.rsp0_valid = (state_q == S_RESP) && !owner_q;
  assign bus.rsp1_valid = (state_q == S_RESP) &&  owner_q;
  assign bus.rsp_data   = rsp_q;

  assign alu_op1    = op1_q;
  assign alu_op2    = op2_q;
  assign alu_fn     = fn_q;
  assign alu_fn_ext = fn_ext_q;
  assign busy       = (state_q != S_IDLE);
  assign owner      = owner_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural RV32 ALU attached.
`default_nettype none

module tb_alu_share_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] alu_op1, alu_op2, alu_res;
  logic [2:0]  alu_fn;
  logic [6:0]  alu_fn_ext;
  logic        busy, owner;

  int n_tests = 0;
  int n_fail  = 0;

  alu_share_arbiter_if #(.XLEN(32)) bus ();

  alu_share_arbiter #(.XLEN(32), .INIT_PRIO(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_fn     (alu_fn),
    .alu_fn_ext (alu_fn_ext),
    .alu_res    (alu_res),
    .busy       (busy),
    .owner      (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External combinational ALU
  always_comb begin
    alu_res = 32'h0;
    case (alu_fn)
      3'b000: alu_res = alu_fn_ext[5] ? alu_op1 - alu_op2 : alu_op1 + alu_op2;
      3'b001: alu_res = alu_op1 << alu_op2[4:0];
      3'b010: alu_res = ($signed(alu_op1) < $signed(alu_op2)) ? 32'd1 : 32'd0;
      3'b011: alu_res = (alu_op1 < alu_op2) ? 32'd1 : 32'd0;
      3'b100: alu_res = alu_op1 ^ alu_op2;
      3'b101: alu_res = alu_fn_ext[5] ? 32'($signed(alu_op1) >>> alu_op2[4:0])
                                      : alu_op1 >> alu_op2[4:0];
      3'b110: alu_res = alu_op1 | alu_op2;
      default: alu_res = alu_op1 & alu_op2;
    endcase
  end

  typedef struct {
    bit          port;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [2:0]  fn;
    logic [6:0]  ext;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input bit port, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [2:0] f, input logic [6:0] e);
    if (!port) begin
      bus.req0_valid = v; bus.req0_op1 = a; bus.req0_op2 = b;
      bus.req0_fn = f; bus.req0_fn_ext = e;
    end else begin
      bus.req1_valid = v; bus.req1_op1 = a; bus.req1_op2 = b;
      bus.req1_fn = f; bus.req1_fn_ext = e;
    end
  endtask

  // Entered and left at posedge+1 with the DUT in IDLE.
  task automatic run_vec(input vec_t v, input int idx);
    bit got;
    got = 1'b0;
    drive_req(v.port, 1'b1, v.op1, v.op2, v.fn, v.ext);
    for (int i = 0; i < 5 && !got; i++) begin
      @(negedge clk);
      if (v.port ? bus.req1_ready : bus.req0_ready) got = 1'b1;
      else @(posedge clk);
    end
    chk($sformatf("v%0d_accept", idx), 32'(got), 32'd1);
    chk($sformatf("v%0d_other_ready", idx),
        32'(v.port ? bus.req0_ready : bus.req1_ready), 32'd0);
    @(posedge clk); #1;
    drive_req(v.port, 1'b0, 32'h0, 32'h0, 3'h0, 7'h0);
    @(negedge clk);
    chk($sformatf("v%0d_exec_busy", idx), 32'(busy), 32'd1);
    chk($sformatf("v%0d_exec_op1", idx), alu_op1, v.op1);
    chk($sformatf("v%0d_exec_fn", idx), {22'h0, alu_fn_ext, alu_fn}, {22'h0, v.ext, v.fn});
    chk($sformatf("v%0d_exec_norsp", idx), 32'({bus.rsp0_valid, bus.rsp1_valid}), 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d_rsp_valid", idx), 32'({bus.rsp0_valid, bus.rsp1_valid}),
        v.port ? 32'd1 : 32'd2);
    chk($sformatf("v%0d_rsp_data", idx), bus.rsp_data, v.exp);
    chk($sformatf("v%0d_owner", idx), 32'(owner), 32'(v.port));
    if (v.port) bus.rsp1_ready = 1'b1; else bus.rsp0_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_idle", idx), 32'({busy, bus.rsp0_valid, bus.rsp1_valid}), 32'd0);
    chk($sformatf("v%0d_owner_hold", idx), 32'(owner), 32'(v.port));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 32'd5,          32'd7,          3'b000, 7'b0000000, 32'h0000000C};
    vecs[1] = '{1'b1, 32'd3,          32'd5,          3'b000, 7'b0100000, 32'hFFFFFFFE};
    vecs[2] = '{1'b1, 32'h80000000,   32'd4,          3'b101, 7'b0100000, 32'hF8000000};
    vecs[3] = '{1'b0, 32'd1,          32'hFFFFFFFF,   3'b011, 7'b0000000, 32'h00000001};
    vecs[4] = '{1'b0, 32'd1,          32'hFFFFFFFF,   3'b010, 7'b0000000, 32'h00000000};
    vecs[5] = '{1'b1, 32'h80000000,   32'd4,          3'b101, 7'b0000000, 32'h08000000};
    vecs[6] = '{1'b0, 32'h000000F0,   32'h0000000F,   3'b110, 7'b0000000, 32'h000000FF};
    vecs[7] = '{1'b1, 32'h00000001,   32'd31,         3'b001, 7'b0000000, 32'h80000000};

    rst = 1'b1;
    drive_req(1'b0, 1'b0, 32'h0, 32'h0, 3'h0, 7'h0);
    drive_req(1'b1, 1'b0, 32'h0, 32'h0, 3'h0, 7'h0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_ctrl", 32'({busy, owner, bus.rsp0_valid, bus.rsp1_valid,
                            bus.req0_ready, bus.req1_ready}), 32'd0);
    chk("reset_alu", {alu_op1 | alu_op2, 22'h0}, 54'h0 >> 22);
    chk("reset_fn", 32'({alu_fn, alu_fn_ext}), 32'd0);
    chk("reset_rsp_data", bus.rsp_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Contention: both requesters valid continuously, grants must alternate 0,1,0,1
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive_req(1'b0, 1'b1, 32'd1,        32'd1,        3'b000, 7'b0000000);
    drive_req(1'b1, 1'b1, 32'h000000F0, 32'h000000FF, 3'b100, 7'b0000000);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("cont%0d_grant", k), 32'({bus.req0_ready, bus.req1_ready}),
          (k % 2) ? 32'd1 : 32'd2);
      chk($sformatf("cont%0d_idle_busy", k), 32'(busy), 32'd0);
      @(negedge clk);
      chk($sformatf("cont%0d_exec", k), 32'({busy, bus.rsp0_valid, bus.rsp1_valid}), 32'd4);
      @(negedge clk);
      chk($sformatf("cont%0d_rsp_valid", k), 32'({bus.rsp0_valid, bus.rsp1_valid}),
          (k % 2) ? 32'd1 : 32'd2);
      chk($sformatf("cont%0d_rsp_data", k), bus.rsp_data,
          (k % 2) ? 32'h0000000F : 32'h00000002);
    end
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 32'h0, 32'h0, 3'h0, 7'h0);
    drive_req(1'b1, 1'b0, 32'h0, 32'h0, 3'h0, 7'h0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;

    // Backpressure on port 0 while port 1 waits
    drive_req(1'b0, 1'b1, 32'd2,  32'd3, 3'b000, 7'b0000000);
    drive_req(1'b1, 1'b1, 32'd10, 32'd3, 3'b000, 7'b0100000);
    @(negedge clk);
    chk("bp_grant0", 32'({bus.req0_ready, bus.req1_ready}), 32'd2);
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 32'h0, 32'h0, 3'h0, 7'h0);
    @(negedge clk);
    chk("bp_exec_req1_ready", 32'(bus.req1_ready), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_rsp0_valid", i), 32'({bus.rsp0_valid, bus.rsp1_valid}), 32'd2);
      chk($sformatf("bp%0d_rsp_data", i), bus.rsp_data, 32'd5);
      chk($sformatf("bp%0d_req1_ready", i), 32'(bus.req1_ready), 32'd0);
    end
    bus.rsp0_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp0_ready = 1'b0;
    @(negedge clk);
    chk("bp_req1_accept", 32'({bus.req1_ready, bus.rsp0_valid}), 32'd2);
    @(posedge clk); #1;
    drive_req(1'b1, 1'b0, 32'h0, 32'h0, 3'h0, 7'h0);
    @(negedge clk);
    @(negedge clk);
    chk("bp_rsp1_valid", 32'({bus.rsp0_valid, bus.rsp1_valid}), 32'd1);
    chk("bp_rsp1_data", bus.rsp_data, 32'd7);
    bus.rsp1_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp1_ready = 1'b0;

    // Reset during EXEC: op discarded, priority restored
    drive_req(1'b0, 1'b1, 32'h000000FF, 32'h0000000F, 3'b111, 7'b0000000);
    @(negedge clk);
    chk("rst_mid_accept", 32'(bus.req0_ready), 32'd1);
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 32'h0, 32'h0, 3'h0, 7'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ctrl", 32'({busy, owner, bus.rsp0_valid, bus.rsp1_valid}), 32'd0);
    chk("rst_mid_op1", alu_op1, 32'd0);
    chk("rst_mid_fn", 32'({alu_fn, alu_fn_ext}), 32'd0);
    chk("rst_mid_data", bus.rsp_data, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst_mid_norsp%0d", i), 32'({busy, bus.rsp0_valid, bus.rsp1_valid}), 32'd0);
    end
    drive_req(1'b0, 1'b1, 32'd1, 32'd1, 3'b000, 7'b0000000);
    drive_req(1'b1, 1'b1, 32'd1, 32'd1, 3'b000, 7'b0000000);
    #1;
    chk("rst_mid_prio", 32'({bus.req0_ready, bus.req1_ready}), 32'd2);
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 32'h0, 32'h0, 3'h0, 7'h0);
    drive_req(1'b1, 1'b0, 32'h0, 32'h0, 3'h0, 7'h0);
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
